// File: rtl/sume_axi_master_seq_pkg.sv
// sume_axi_master_seq_pkg: sequencer state encoding and response status codes.
package sume_axi_master_seq_pkg;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_RSP   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;
    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
endpackage

// File: rtl/sume_axi_master_seq.sv
// sume_axi_master_seq: one-at-a-time command sequencer in front of an IPIF master, with timeout and statistics.
module sume_axi_master_seq
    import sume_axi_master_seq_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_TIMEOUT          = 1024,
    parameter int C_CNT_WIDTH        = 32
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    input  logic                              CMD_VALID,
    output logic                              CMD_READY,
    input  logic                              CMD_WR,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     CMD_ADDR,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     CMD_DATA,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   CMD_BE,
    output logic                              RSP_VALID,
    input  logic                              RSP_READY,
    output logic                              RSP_WR,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     RSP_DATA,
    output logic [1:0]                        RSP_STATUS,
    output logic                              IP2Bus_MstWr_Req,
    output logic                              IP2Bus_MstRd_Req,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     IP2Bus_Mst_Addr,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   IP2Bus_Mst_BE,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     IP2Bus_MstWr_d,
    input  logic                              Bus2IP_Mst_CmdAck,
    input  logic                              Bus2IP_Mst_Cmplt,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     Bus2IP_MstRd_d,
    output logic [C_CNT_WIDTH-1:0]            WR_COUNT,
    output logic [C_CNT_WIDTH-1:0]            RD_COUNT,
    output logic [C_CNT_WIDTH-1:0]            TO_COUNT
);
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int BW = DW / 8;
    localparam int CW = C_CNT_WIDTH;
    localparam logic [31:0] TO_LAST = (C_TIMEOUT > 0) ? 32'(C_TIMEOUT - 1) : 32'd0;

    state_t          state_q, state_d;
    logic            pend_q, pend_d;
    logic [31:0]     to_q, to_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [BW-1:0]   be_q, be_d;
    logic [DW-1:0]   wd_q, wd_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [1:0]      status_q, status_d;
    logic [CW-1:0]   wcnt_q, wcnt_d, rcnt_q, rcnt_d, tcnt_q, tcnt_d;
    logic            cmd_ready_q, rsp_valid_q, wreq_q, rreq_q;
    logic            unused_cmdack;

    assign unused_cmdack = Bus2IP_Mst_CmdAck;

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        to_d     = (state_q == S_BUSY) ? to_q + 32'd1 : 32'd0;
        wr_d     = wr_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wd_d     = wd_q;
        rdata_d  = rdata_q;
        status_d = status_q;
        wcnt_d   = wcnt_q;
        rcnt_d   = rcnt_q;
        tcnt_d   = tcnt_q;
        case (state_q)
            S_IDLE: if (cmd_ready_q && CMD_VALID) begin
                state_d = S_BUSY;
                wr_d    = CMD_WR;
                addr_d  = CMD_ADDR;
                be_d    = CMD_BE;
                wd_d    = CMD_WR ? CMD_DATA : '0;
            end
            S_BUSY: begin
                // completion takes priority over a coincident timeout
                if (Bus2IP_Mst_Cmplt) begin
                    state_d  = S_RSP;
                    rdata_d  = wr_q ? '0 : Bus2IP_MstRd_d;
                    status_d = ST_OK;
                    wcnt_d   = wr_q ? wcnt_q + CW'(1) : wcnt_q;
                    rcnt_d   = wr_q ? rcnt_q : rcnt_q + CW'(1);
                end else if (C_TIMEOUT != 0 && to_q == TO_LAST) begin
                    state_d  = S_RSP;
                    rdata_d  = '0;
                    status_d = ST_TIMEOUT;
                    tcnt_d   = tcnt_q + CW'(1);
                    pend_d   = 1'b1;
                end
                if (state_d == S_RSP) begin
                    addr_d = '0;
                    be_d   = '0;
                    wd_d   = '0;
                end
            end
            S_RSP: begin
                if (Bus2IP_Mst_Cmplt) pend_d = 1'b0;
                if (RSP_READY) begin
                    state_d  = pend_d ? S_DRAIN : S_IDLE;
                    wr_d     = 1'b0;
                    rdata_d  = '0;
                    status_d = ST_OK;
                end
            end
            S_DRAIN: if (Bus2IP_Mst_Cmplt) begin
                pend_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= S_IDLE;
            pend_q      <= 1'b0;
            to_q        <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wd_q        <= '0;
            rdata_q     <= '0;
            status_q    <= ST_OK;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            tcnt_q      <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            wreq_q      <= 1'b0;
            rreq_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            to_q        <= to_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wd_q        <= wd_d;
            rdata_q     <= rdata_d;
            status_q    <= status_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            tcnt_q      <= tcnt_d;
            cmd_ready_q <= state_d == S_IDLE;
            rsp_valid_q <= state_d == S_RSP;
            wreq_q      <= state_d == S_BUSY && wr_d;
            rreq_q      <= state_d == S_BUSY && !wr_d;
        end
    end

    assign CMD_READY        = cmd_ready_q;
    assign RSP_VALID        = rsp_valid_q;
    assign RSP_WR           = wr_q & rsp_valid_q;
    assign RSP_DATA         = rdata_q;
    assign RSP_STATUS       = status_q;
    assign IP2Bus_MstWr_Req = wreq_q;
    assign IP2Bus_MstRd_Req = rreq_q;
    assign IP2Bus_Mst_Addr  = addr_q;
    assign IP2Bus_Mst_BE    = be_q;
    assign IP2Bus_MstWr_d   = wd_q;
    assign WR_COUNT         = wcnt_q;
    assign RD_COUNT         = rcnt_q;
    assign TO_COUNT         = tcnt_q;
endmodule
